note_sequence_recorder: RTL and testbench

//  Records a note sequence from the player keys and packs it into the level word that the

---
 rtl/note_sequence_recorder.sv | 137 +++++++++++++
 tb/tb_note_sequence_recorder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/note_sequence_recorder.sv
// Records debounced single-key presses into a packed nibble word (first note in the top nibble)
// and hands the completed level to the playback/response shifters with a valid/ack handshake.
module note_sequence_recorder #(
    parameter int MAX_NOTES       = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   finish,
    input  logic [3:0]             note_inputs,
    input  logic                   level_ack,
    output logic [4*MAX_NOTES-1:0] level_data,
    output logic [3:0]             level_length,
    output logic                   level_valid,
    output logic                   busy,
    output logic                   note_stored,
    output logic                   multi_key,
    output logic [3:0]             note_echo
);

    // state        | meaning
    // IDLE         | waiting for start; last level held on outputs
    // ARM          | waiting for all keys released before accepting notes
    // WAIT_PRESS   | waiting for a key pattern (or finish)
    // DEBOUNCE     | candidate pattern must stay stable DEBOUNCE_CYCLES cycles
    // WAIT_RELEASE | waiting for all keys released for DEBOUNCE_CYCLES cycles
    // DONE         | level complete, level_valid high until level_ack
    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE, DONE
    } state_t;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

    state_t                 state, state_n;
    logic [3:0]             sync1, sync;
    logic [3:0]             cand, cand_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [4*MAX_NOTES-1:0] data_n;
    logic [3:0]             len_n;
    logic                   stored_n, multi_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= '0;
            sync         <= '0;
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            level_data   <= '0;
            level_length <= '0;
            note_stored  <= 1'b0;
            multi_key    <= 1'b0;
        end else begin
            sync1        <= note_inputs;
            sync         <= sync1;
            state        <= state_n;
            cand         <= cand_n;
            cnt          <= cnt_n;
            level_data   <= data_n;
            level_length <= len_n;
            note_stored  <= stored_n;
            multi_key    <= multi_n;
        end
    end

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        data_n   = level_data;
        len_n    = level_length;
        stored_n = 1'b0;
        multi_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    data_n  = '0;
                    len_n   = '0;
                    cnt_n   = CNT_LOAD;
                    state_n = ARM;
                end
            end
            ARM, WAIT_RELEASE: begin
                // Any key activity restarts the quiet-period countdown.
                if (sync != 4'd0) begin
                    cnt_n = CNT_LOAD;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (state == ARM || level_length != 4'(MAX_NOTES)) begin
                    state_n = WAIT_PRESS;
                end else begin
                    state_n = DONE;
                end
            end
            WAIT_PRESS: begin
                if (sync != 4'd0) begin
                    cand_n  = sync;
                    cnt_n   = CNT_LOAD;
                    state_n = DEBOUNCE;
                end else if (finish && level_length != 4'd0) begin
                    state_n = DONE;
                end
            end
            DEBOUNCE: begin
                if (sync != cand) begin
                    state_n = WAIT_PRESS;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    if ($onehot(cand)) begin
                        for (int i = 0; i < MAX_NOTES; i++) begin
                            if (level_length == 4'(i))
                                data_n[4*(MAX_NOTES-i)-1 -: 4] = cand;
                        end
                        len_n    = level_length + 4'd1;
                        stored_n = 1'b1;
                    end else begin
                        multi_n = 1'b1;
                    end
                    cnt_n   = CNT_LOAD;
                    state_n = WAIT_RELEASE;
                end
            end
            DONE: begin
                if (level_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign level_valid = (state == DONE);
    assign busy        = (state != IDLE);
    assign note_echo   = sync;

endmodule

// File: tb/tb_note_sequence_recorder.sv
// Directed bench for note_sequence_recorder: clean presses, glitch rejection, multi-key,
// early finish, held key at start, and asynchronous reset mid-recording.
module tb_note_sequence_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, finish, level_ack;
    logic [3:0]  note_inputs;
    logic [15:0] level_data;
    logic [3:0]  level_length;
    logic        level_valid, busy, note_stored, multi_key;
    logic [3:0]  note_echo;

    int vectors     = 0;
    int miscompares = 0;
    int n_stored    = 0;
    int n_multi     = 0;
    int base_st, base_mk;

    note_sequence_recorder #(.MAX_NOTES(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .note_inputs(note_inputs), .level_ack(level_ack),
        .level_data(level_data), .level_length(level_length),
        .level_valid(level_valid), .busy(busy), .note_stored(note_stored),
        .multi_key(multi_key), .note_echo(note_echo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (note_stored === 1'b1) n_stored++;
        if (multi_key === 1'b1) n_multi++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] pat, input int hold, input int gap);
        note_inputs = pat;
        tick(hold);
        note_inputs = 4'd0;
        tick(gap);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; tick(); finish = 1'b0;
    endtask

    task automatic pulse_ack();
        level_ack = 1'b1; tick(); level_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; level_ack = 1'b0; note_inputs = 4'd0;
        tick(3);
        chk("rst_data", level_data, 16'h0);
        chk("rst_len", level_length, 4'd0);
        chk("rst_valid", level_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick(2);

        // 1: four clean presses fill the level
        base_st = n_stored;
        pulse_start();
        chk("t1_busy", busy, 1'b1);
        tick(6);
        press(4'h8, 10, 10);
        press(4'h4, 10, 10);
        press(4'h2, 10, 10);
        press(4'h1, 10, 10);
        chk("t1_data", level_data, 16'h8421);
        chk("t1_len", level_length, 4'd4);
        chk("t1_valid", level_valid, 1'b1);
        chk("t1_stores", n_stored - base_st, 4);
        pulse_ack();
        chk("t1_valid_drop", level_valid, 1'b0);
        chk("t1_idle", busy, 1'b0);
        chk("t1_hold_data", level_data, 16'h8421);

        // 2: glitch rejected, then a clean press with exact store latency
        base_st = n_stored;
        pulse_start();
        chk("t2_cleared", level_data, 16'h0);
        tick(6);
        press(4'h2, 3, 10);
        chk("t2_glitch", n_stored - base_st, 0);
        note_inputs = 4'h2;
        tick(6);
        chk("t2_not_yet", level_length, 4'd0);
        tick();
        chk("t2_latency", level_length, 4'd1);
        chk("t2_echo", note_echo, 4'h2);
        tick(3);
        note_inputs = 4'd0;
        tick(10);
        chk("t2_stores", n_stored - base_st, 1);
        chk("t2_nibble", level_data[15:12], 4'h2);
        pulse_finish();
        chk("t2_valid", level_valid, 1'b1);
        chk("t2_data", level_data, 16'h2000);
        pulse_ack();

        // 3: multi-key rejected; 4: finish with zero notes ignored, then two notes and finish
        base_st = n_stored;
        base_mk = n_multi;
        pulse_start();
        tick(6);
        press(4'b0011, 10, 10);
        chk("t3_multi", n_multi - base_mk, 1);
        chk("t3_nostore", n_stored - base_st, 0);
        chk("t3_len", level_length, 4'd0);
        pulse_finish();
        tick(2);
        chk("t4_fin0_valid", level_valid, 1'b0);
        chk("t4_fin0_busy", busy, 1'b1);
        press(4'h1, 10, 10);
        press(4'h8, 10, 10);
        pulse_finish();
        chk("t4_valid", level_valid, 1'b1);
        chk("t4_data", level_data, 16'h1800);
        chk("t4_len", level_length, 4'd2);
        pulse_start();
        tick(2);
        chk("t4_start_ign", level_valid, 1'b1);
        chk("t4_hold", level_data, 16'h1800);
        pulse_ack();

        // 5: key held at start is not recorded
        base_st = n_stored;
        note_inputs = 4'h4;
        tick(3);
        pulse_start();
        tick(20);
        chk("t5_arm_busy", busy, 1'b1);
        chk("t5_held_nostore", n_stored - base_st, 0);
        note_inputs = 4'd0;
        tick(10);
        press(4'h8, 10, 10);
        pulse_finish();
        chk("t5_len", level_length, 4'd1);
        chk("t5_data", level_data, 16'h8000);
        pulse_ack();

        // 6: start+finish together in IDLE -> start wins; then async reset mid-recording
        start = 1'b1; finish = 1'b1; tick(); start = 1'b0; finish = 1'b0;
        chk("t6_start_wins", busy, 1'b1);
        chk("t6_not_done", level_valid, 1'b0);
        tick(6);
        press(4'h2, 10, 10);
        press(4'h4, 10, 10);
        chk("t6_len2", level_length, 4'd2);
        note_inputs = 4'h1;
        tick(3);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_data", level_data, 16'h0);
        chk("t6_rst_len", level_length, 4'd0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_echo", note_echo, 4'h0);
        note_inputs = 4'd0;
        #2 reset = 1'b0;
        tick(2);
        pulse_start();
        tick(6);
        press(4'h1, 10, 10);
        pulse_finish();
        chk("t6_fresh_data", level_data, 16'h1000);
        chk("t6_fresh_len", level_length, 4'd1);
        pulse_ack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
